// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared widths, reset PC and fetch FSM state encodings for the
//               20-bit CPU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

  localparam int ADDR_W  = 20;
  localparam int INSTR_W = 20;
  localparam logic [ADDR_W-1:0] RESET_PC = 20'h00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_e;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Architectural program counter. Redirect load wins over the
//               sequential increment; increment wraps modulo 2^WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
  parameter int                 WIDTH     = cpu_defs::ADDR_W,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_pc,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_pc
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_pc;

  // PC update: reset, then redirect load, then increment, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VAL;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + c_one;
    end
  end

  assign o_pc = r_pc;

endmodule : pc_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC / instruction-fetch stage. One outstanding imem read at a
//               time, fetched instruction handed to decode via valid/ready,
//               redirects from the branch operator squash in-flight work.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                  ADDR_W   = cpu_defs::ADDR_W,
  parameter int                  INSTR_W  = cpu_defs::INSTR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = cpu_defs::RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_pc
);

  import cpu_defs::*;

  state_e               r_state;
  logic                 r_kill;
  logic [ADDR_W-1:0]    r_hold_addr;
  logic [INSTR_W-1:0]   r_instr;
  logic [ADDR_W-1:0]    r_instr_pc;
  logic                 r_imem_req;
  logic                 r_instr_valid;
  logic [ADDR_W-1:0]    w_pc;
  logic                 w_accept;

  // A response is kept only if no redirect is pending or arriving with it
  assign w_accept = (r_state == FETCH) && imem_ready && !r_kill && !branch_valid;

  pc_reg #(
    .WIDTH     (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (branch_valid),
    .i_load_pc (branch_pc),
    .i_inc     (w_accept),
    .o_pc      (w_pc)
  );

  // While a killed request is outstanding the PC already holds the redirect
  // target, so the in-flight address comes from the hold register instead.
  assign imem_addr   = r_kill ? r_hold_addr : w_pc;
  assign imem_req    = r_imem_req;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

  // Fetch FSM with kill tracking, instruction register and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_kill        <= 1'b0;
      r_hold_addr   <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            if (w_accept) begin
              r_instr       <= imem_rdata;
              r_instr_pc    <= w_pc;
              r_state       <= ISSUE;
              r_imem_req    <= 1'b0;
              r_instr_valid <= 1'b1;
            end else begin
              r_kill <= 1'b0;
            end
          end else if (branch_valid && !r_kill) begin
            r_kill      <= 1'b1;
            r_hold_addr <= w_pc;
          end
        end
        ISSUE: begin
          if (branch_valid || instr_ready) begin
            r_state       <= FETCH;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with a wait-state memory
//               model and an issued-instruction scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [19:0] imem_addr;
  logic        imem_ready;
  logic [19:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [19:0] instr;
  logic [19:0] instr_pc;
  logic        branch_valid;
  logic [19:0] branch_pc;

  // second instance exercising the PC wrap from RESET_PC = all ones
  logic        b_req;
  logic [19:0] b_addr;
  logic        b_ready;
  logic [19:0] b_rdata;
  logic        b_valid;
  logic        b_instr_ready;
  logic [19:0] b_instr;
  logic [19:0] b_instr_pc;
  logic        b_branch_valid;
  logic [19:0] b_branch_pc;

  int          waits;
  int          wcnt;
  int          n_tests;
  int          n_fail;
  logic [39:0] exp_q[$];

  function automatic logic [19:0] memf(input logic [19:0] a);
    return a ^ 20'h0A0A0;
  endfunction

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .branch_valid(branch_valid), .branch_pc(branch_pc)
  );

  fetch_unit #(.RESET_PC(20'hFFFFF)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(b_ready), .imem_rdata(b_rdata), .instr_valid(b_valid),
    .instr_ready(b_instr_ready), .instr(b_instr), .instr_pc(b_instr_pc),
    .branch_valid(b_branch_valid), .branch_pc(b_branch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: ready after 'waits' stalled cycles, data is a function of address
  assign imem_ready = imem_req && (wcnt >= waits);
  assign imem_rdata = memf(imem_addr);
  assign b_ready    = 1'b1;
  assign b_rdata    = memf(b_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wcnt <= 0;
    else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  // scoreboard: every non-squashed handshake must match the next expectation
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !branch_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got pc=%h instr=%h, required no instruction", instr_pc, instr);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          n_fail++;
          $display("FAIL issue_data: got pc=%h instr=%h, required pc=%h instr=%h",
                   instr_pc, instr, e[39:20], e[19:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    instr_ready  = 1'b0;
    branch_valid = 1'b0;
    branch_pc    = 20'h0;
    waits        = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 5;
    if (imem_req !== 1'b0)      begin n_fail++; $display("FAIL rst_req: got %b, required 0", imem_req); end
    if (instr_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
    if (instr !== 20'h0)        begin n_fail++; $display("FAIL rst_instr: got %h, required 00000", instr); end
    if (instr_pc !== 20'h0)     begin n_fail++; $display("FAIL rst_instr_pc: got %h, required 00000", instr_pc); end
    if (imem_addr !== 20'h0)    begin n_fail++; $display("FAIL rst_addr: got %h, required 00000", imem_addr); end
    tick();
    n_tests += 2;
    if (imem_req !== 1'b1)      begin n_fail++; $display("FAIL first_req: got %b, required 1", imem_req); end
    if (imem_addr !== 20'h0)    begin n_fail++; $display("FAIL first_addr: got %h, required 00000", imem_addr); end
    tick();
    n_tests += 3;
    if (instr_valid !== 1'b1)   begin n_fail++; $display("FAIL first_valid: got %b, required 1", instr_valid); end
    if (instr !== 20'h0A0A0)    begin n_fail++; $display("FAIL first_instr: got %h, required 0a0a0", instr); end
    if (instr_pc !== 20'h0)     begin n_fail++; $display("FAIL first_pc: got %h, required 00000", instr_pc); end
    exp_q.push_back({20'h0, 20'h0A0A0});
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_tests += 2;
    if (imem_addr !== 20'h1)    begin n_fail++; $display("FAIL second_addr: got %h, required 00001", imem_addr); end
    if (instr_valid !== 1'b0)   begin n_fail++; $display("FAIL second_valid: got %b, required 0", instr_valid); end
  endtask

  task automatic test_stall();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests += 4;
      if (instr_valid !== 1'b1)     begin n_fail++; $display("FAIL stall_valid[%0d]: got %b, required 1", i, instr_valid); end
      if (instr !== memf(20'h1))    begin n_fail++; $display("FAIL stall_instr[%0d]: got %h, required %h", i, instr, memf(20'h1)); end
      if (instr_pc !== 20'h1)       begin n_fail++; $display("FAIL stall_pc[%0d]: got %h, required 00001", i, instr_pc); end
      if (imem_req !== 1'b0)        begin n_fail++; $display("FAIL stall_req[%0d]: got %b, required 0", i, imem_req); end
      tick();
    end
    exp_q.push_back({20'h1, memf(20'h1)});
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_tests += 2;
    if (imem_req !== 1'b1)   begin n_fail++; $display("FAIL stall_next_req: got %b, required 1", imem_req); end
    if (imem_addr !== 20'h2) begin n_fail++; $display("FAIL stall_next_addr: got %h, required 00002", imem_addr); end
  endtask

  task automatic test_branch_issue();
    tick();
    n_tests += 1;
    if (instr_pc !== 20'h2) begin n_fail++; $display("FAIL br_issue_pc: got %h, required 00002", instr_pc); end
    instr_ready  = 1'b1;
    branch_valid = 1'b1;
    branch_pc    = 20'h00400;
    tick();
    instr_ready  = 1'b0;
    branch_valid = 1'b0;
    n_tests += 3;
    if (instr_valid !== 1'b0)    begin n_fail++; $display("FAIL br_squash_valid: got %b, required 0", instr_valid); end
    if (imem_req !== 1'b1)       begin n_fail++; $display("FAIL br_req: got %b, required 1", imem_req); end
    if (imem_addr !== 20'h00400) begin n_fail++; $display("FAIL br_addr: got %h, required 00400", imem_addr); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [19:0] a;
      a = 20'h00400 + 20'(i);
      exp_q.push_back({a, memf(a)});
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    instr_ready = 1'b0;
    n_tests += 2;
    if (exp_q.size() != 0)       begin n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
    if (imem_addr !== 20'h00404) begin n_fail++; $display("FAIL b2b_addr: got %h, required 00404", imem_addr); end
  endtask

  task automatic test_wait_kill();
    int lat;
    waits        = 3;
    branch_valid = 1'b1;
    branch_pc    = 20'h12345;
    tick();
    branch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests += 3;
      if (imem_req !== 1'b1)       begin n_fail++; $display("FAIL kill_req[%0d]: got %b, required 1", i, imem_req); end
      if (imem_addr !== 20'h00404) begin n_fail++; $display("FAIL kill_hold_addr[%0d]: got %h, required 00404", i, imem_addr); end
      if (instr_valid !== 1'b0)    begin n_fail++; $display("FAIL kill_valid[%0d]: got %b, required 0", i, instr_valid); end
      tick();
    end
    n_tests += 3;
    if (imem_req !== 1'b1)       begin n_fail++; $display("FAIL kill_new_req: got %b, required 1", imem_req); end
    if (imem_addr !== 20'h12345) begin n_fail++; $display("FAIL kill_new_addr: got %h, required 12345", imem_addr); end
    if (instr_valid !== 1'b0)    begin n_fail++; $display("FAIL kill_drop: got %b, required 0", instr_valid); end
    lat = 0;
    while (instr_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_tests += 1;
    if (lat != 4) begin n_fail++; $display("FAIL wait_latency: got %0d cycles, required 4", lat); end
    exp_q.push_back({20'h12345, memf(20'h12345)});
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_tests += 1;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL kill_issue: got %0d pending, required 0", exp_q.size()); end
    waits = 0;
  endtask

  task automatic test_async_reset();
    waits = 3;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests += 3;
    if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL arst_req: got %b, required 0", imem_req); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b, required 0", instr_valid); end
    if (imem_addr !== 20'h0)  begin n_fail++; $display("FAIL arst_addr: got %h, required 00000", imem_addr); end
    tick();
    tick();
    waits = 0;
    rst_n = 1'b1;
    tick();
    n_tests += 2;
    if (imem_req !== 1'b1)   begin n_fail++; $display("FAIL arst_restart_req: got %b, required 1", imem_req); end
    if (imem_addr !== 20'h0) begin n_fail++; $display("FAIL arst_restart_addr: got %h, required 00000", imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    n_tests += 2;
    if (b_req !== 1'b1)        begin n_fail++; $display("FAIL wrap_req: got %b, required 1", b_req); end
    if (b_addr !== 20'hFFFFF)  begin n_fail++; $display("FAIL wrap_first_addr: got %h, required fffff", b_addr); end
    tick();
    n_tests += 2;
    if (b_instr_pc !== 20'hFFFFF)     begin n_fail++; $display("FAIL wrap_instr_pc: got %h, required fffff", b_instr_pc); end
    if (b_instr !== memf(20'hFFFFF))  begin n_fail++; $display("FAIL wrap_instr: got %h, required %h", b_instr, memf(20'hFFFFF)); end
    tick();
    n_tests += 1;
    if (b_addr !== 20'h00000) begin n_fail++; $display("FAIL wrap_next_addr: got %h, required 00000", b_addr); end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    b_instr_ready  = 1'b1;
    b_branch_valid = 1'b0;
    b_branch_pc    = 20'h0;
    test_reset();
    test_stall();
    test_branch_issue();
    test_back_to_back();
    test_wait_kill();
    test_async_reset();
    test_wrap();
    n_tests += 1;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_unit
`default_nettype wire
